mc_controller: RTL and testbench

Multicycle control unit for the MIPS datapath: decodes the instruction-register opcode/funct and sequences one instruction over 3–5 cycles. It drives every datapath mux select and write enable, and drives the 3-bit `alucontrol` code into the ALU. It consumes the ALU `zero` flag to resolve branches. It sits between the instruction register and the datapath, with the ALU on the far end of the `alucontrol`/`zero` interface.

---
 rtl/mc_controller_if.sv | 31 +++
 rtl/mc_controller.sv | 154 +++++++++++++++
 tb/tb_mc_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath:
// instruction fields and the ALU zero flag flow in, mux selects, write
// enables and the ALU operation code flow out.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit. A Moore FSM sequences each instruction
// through FETCH/DECODE and an opcode-specific tail; its outputs are held in
// a register loaded with the decode of the state being entered. Reset
// blanks every output combinationally so no write completes in a reset
// cycle; zero -> pcen is the only same-cycle input path.
module mc_controller (
  input  logic             clk,
  input  logic             reset,
  mc_controller_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl_q;

  function automatic logic [2:0] alu_funct(input logic [5:0] f);
    case (f)
      6'b100000: alu_funct = 3'b010;
      6'b100010: alu_funct = 3'b110;
      6'b100100: alu_funct = 3'b000;
      6'b100101: alu_funct = 3'b001;
      6'b101010: alu_funct = 3'b111;
      default:   alu_funct = 3'b010;
    endcase
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] o);
    case (s)
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (o)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (o == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state = MEMWB;
      RTYPEEX: next_state = RTYPEWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01; c.alucontrol = ALU_ADD;
        c.irwrite = 1'b1;  c.pcwrite    = 1'b1;
      end
      DECODE: begin
        c.alusrcb = 2'b11; c.alucontrol = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = ALU_ADD;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1; c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord = 1'b1; c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1; c.alucontrol = alu_funct(f);
      end
      RTYPEWB: begin
        c.regdst = 1'b1; c.regwrite = 1'b1;
      end
      BEQEX: begin
        c.alusrca = 1'b1; c.alucontrol = ALU_SUB;
        c.pcsrc   = 2'b01; c.branch    = 1'b1;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JEX: begin
        c.pcsrc = 2'b10; c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection from the current state and the held opcode.
  always_comb nxt = next_state(state, bus.op);

  // State register plus output register preloaded with the entered state's decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      ctrl_q <= decode_ctrl(FETCH, bus.funct);
    end else begin
      state  <= nxt;
      ctrl_q <= decode_ctrl(nxt, bus.funct);
    end
  end

  assign bus.iord       = ~reset & ctrl_q.iord;
  assign bus.memwrite   = ~reset & ctrl_q.memwrite;
  assign bus.irwrite    = ~reset & ctrl_q.irwrite;
  assign bus.regdst     = ~reset & ctrl_q.regdst;
  assign bus.memtoreg   = ~reset & ctrl_q.memtoreg;
  assign bus.regwrite   = ~reset & ctrl_q.regwrite;
  assign bus.alusrca    = ~reset & ctrl_q.alusrca;
  assign bus.alusrcb    = reset ? 2'b00 : ctrl_q.alusrcb;
  assign bus.pcsrc      = reset ? 2'b00 : ctrl_q.pcsrc;
  assign bus.alucontrol = reset ? 3'b000 : ctrl_q.alucontrol;
  assign bus.pcen       = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & bus.zero));

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: a per-cycle table of inputs and
// expected outputs, plus a hand-written sequence toggling zero within BEQEX.
module tb_mc_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout:
  // [14]iord [13]memwrite [12]irwrite [11]regdst [10]memtoreg [9]regwrite
  // [8]alusrca [7:6]alusrcb [5:4]pcsrc [3]pcen [2:0]alucontrol
  localparam logic [14:0] E_ZERO   = 15'b0_0_0_0_0_0_0_00_00_0_000;
  localparam logic [14:0] E_FETCH  = 15'b0_0_1_0_0_0_0_01_00_1_010;
  localparam logic [14:0] E_DECODE = 15'b0_0_0_0_0_0_0_11_00_0_010;
  localparam logic [14:0] E_MEMADR = 15'b0_0_0_0_0_0_1_10_00_0_010;
  localparam logic [14:0] E_MEMRD  = 15'b1_0_0_0_0_0_0_00_00_0_000;
  localparam logic [14:0] E_MEMWB  = 15'b0_0_0_0_1_1_0_00_00_0_000;
  localparam logic [14:0] E_MEMWR  = 15'b1_1_0_0_0_0_0_00_00_0_000;
  localparam logic [14:0] E_RTWB   = 15'b0_0_0_1_0_1_0_00_00_0_000;
  localparam logic [14:0] E_ADDIWB = 15'b0_0_0_0_0_1_0_00_00_0_000;
  localparam logic [14:0] E_JEX    = 15'b0_0_0_0_0_0_0_00_10_1_000;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  function automatic logic [14:0] e_rtex(input logic [2:0] alu);
    return {12'b0_0_0_0_0_0_1_00_00_0, alu};
  endfunction

  function automatic logic [14:0] e_beq(input logic z);
    return {11'b0_0_0_0_0_0_1_00_01, z, 3'b110};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] sample();
    return {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
            bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
            bus.alucontrol};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [14:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [14:0] exp);
    logic [14:0] got;
    got = sample();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic add_rtype(input logic [5:0] f, input logic [2:0] alu);
    add(0, OP_R, f, 0, E_FETCH);
    add(0, OP_R, f, 0, E_DECODE);
    add(0, OP_R, f, 0, e_rtex(alu));
    add(0, OP_R, f, 0, E_RTWB);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    // reset held three cycles
    repeat (3) add(1, OP_R, 6'd0, 0, E_ZERO);
    // lw: 5 cycles
    add(0, OP_LW, 6'd0, 0, E_FETCH);
    add(0, OP_LW, 6'd0, 0, E_DECODE);
    add(0, OP_LW, 6'd0, 0, E_MEMADR);
    add(0, OP_LW, 6'd0, 0, E_MEMRD);
    add(0, OP_LW, 6'd0, 0, E_MEMWB);
    // sw: 4 cycles
    add(0, OP_SW, 6'd0, 0, E_FETCH);
    add(0, OP_SW, 6'd0, 0, E_DECODE);
    add(0, OP_SW, 6'd0, 0, E_MEMADR);
    add(0, OP_SW, 6'd0, 0, E_MEMWR);
    // R-type funct decode
    add_rtype(6'b100010, 3'b110);
    add_rtype(6'b100100, 3'b000);
    add_rtype(6'b100101, 3'b001);
    add_rtype(6'b101010, 3'b111);
    add_rtype(6'b100000, 3'b010);
    add_rtype(6'b111111, 3'b010);
    // beq taken / not taken
    add(0, OP_BEQ, 6'd0, 1, E_FETCH);
    add(0, OP_BEQ, 6'd0, 1, E_DECODE);
    add(0, OP_BEQ, 6'd0, 1, e_beq(1'b1));
    add(0, OP_BEQ, 6'd0, 0, E_FETCH);
    add(0, OP_BEQ, 6'd0, 0, E_DECODE);
    add(0, OP_BEQ, 6'd0, 0, e_beq(1'b0));
    // addi
    add(0, OP_ADDI, 6'd0, 0, E_FETCH);
    add(0, OP_ADDI, 6'd0, 0, E_DECODE);
    add(0, OP_ADDI, 6'd0, 0, E_MEMADR);
    add(0, OP_ADDI, 6'd0, 0, E_ADDIWB);
    // j
    add(0, OP_J, 6'd0, 0, E_FETCH);
    add(0, OP_J, 6'd0, 0, E_DECODE);
    add(0, OP_J, 6'd0, 0, E_JEX);
    // illegal op: FETCH, DECODE, back to FETCH
    add(0, OP_BAD, 6'd0, 0, E_FETCH);
    add(0, OP_BAD, 6'd0, 0, E_DECODE);
    // sw with reset in MEMWR
    add(0, OP_SW, 6'd0, 0, E_FETCH);
    add(0, OP_SW, 6'd0, 0, E_DECODE);
    add(0, OP_SW, 6'd0, 0, E_MEMADR);
    add(1, OP_SW, 6'd0, 0, E_ZERO);
    // R-type with reset in RTYPEWB
    add(0, OP_R, 6'b100000, 0, E_FETCH);
    add(0, OP_R, 6'b100000, 0, E_DECODE);
    add(0, OP_R, 6'b100000, 0, e_rtex(3'b010));
    add(1, OP_R, 6'b100000, 0, E_ZERO);
    // beq with reset in BEQEX while zero is high
    add(0, OP_BEQ, 6'd0, 1, E_FETCH);
    add(0, OP_BEQ, 6'd0, 1, E_DECODE);
    add(1, OP_BEQ, 6'd0, 1, E_ZERO);
    // recovery into FETCH; the next beq continues by hand below
    add(0, OP_BEQ, 6'd0, 0, E_FETCH);

    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst;
      bus.op    = vecs[i].op;
      bus.funct = vecs[i].funct;
      bus.zero  = vecs[i].zero;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // beq from the last table FETCH: DECODE, then zero toggled within BEQEX
    bus.zero = 1'b0;
    #1;
    check("beq_toggle_decode", E_DECODE);
    @(posedge clk);
    #1;
    bus.zero = 1'b0;
    #1;
    check("beq_toggle_z0", e_beq(1'b0));
    bus.zero = 1'b1;
    #1;
    check("beq_toggle_z1", e_beq(1'b1));
    bus.zero = 1'b0;
    #1;
    check("beq_toggle_z0b", e_beq(1'b0));
    @(posedge clk);
    #1;
    check("beq_toggle_fetch", E_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
